// File: rtl/seqdet_pkg.sv
// Shared definitions for the parametrised sequence detector.
package seqdet_pkg;

   // Widest pattern the detector supports; the length mask is built at this width.
   localparam int unsigned MASK_W = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_ERR  = 2'd2
   } state_e;

   // Ones in bit positions [len-1:0], zeros above.
   function automatic logic [MASK_W-1:0] len_mask(input int unsigned len);
      logic [MASK_W-1:0] m;
      m = '0;
      for (int unsigned i = 0; i < MASK_W; i++) begin
         m[i] = (i < len);
      end
      return m;
   endfunction

endpackage

// File: rtl/seqdet_match_cnt.sv
// Generic saturating up-counter with synchronous clear.
module seqdet_match_cnt #(
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_clr,
   input  logic             i_inc,
   output logic [CNT_W-1:0] o_cnt
);

   logic [CNT_W-1:0] r_cnt;

   // Clear wins over increment; increment stops at all-ones.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_inc && (r_cnt != '1)) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   assign o_cnt = r_cnt;

endmodule

// File: rtl/seq_detector_param.sv
// Serial pattern detector with runtime pattern/length, overlap mode,
// enable gating, saturating match counter and config error flag.
module seq_detector_param
   import seqdet_pkg::*;
#(
   parameter int unsigned MAX_LEN = 8,
   parameter int unsigned CNT_W   = 8,
   parameter int unsigned LEN_W   = $clog2(MAX_LEN + 1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cfg_load,
   input  logic [MAX_LEN-1:0] pattern,
   input  logic [LEN_W-1:0]   len,
   input  logic               overlap,
   input  logic               en,
   input  logic               x,
   output logic               z,
   output logic [CNT_W-1:0]   match_cnt,
   output logic               cfg_err,
   output logic [1:0]         state,
   output logic [LEN_W-1:0]   fill
);

   state_e             r_state;
   // The oldest history bit can never take part in a compare, so only
   // MAX_LEN-1 bits are stored; the incoming bit completes the window.
   logic [MAX_LEN-2:0] r_hist;
   logic [LEN_W-1:0]   r_fill;
   logic [MAX_LEN-1:0] r_pat;
   logic [LEN_W-1:0]   r_len;
   logic               r_ovl;
   logic               r_z;
   logic               r_cfg_err;

   logic [MAX_LEN-1:0] w_hist_n;
   logic [LEN_W-1:0]   w_fill_inc;
   logic [MASK_W-1:0]  w_mask;
   logic [MASK_W-1:0]  w_diff;
   logic               w_len_ok;
   logic               w_sample;
   logic               w_match;

   assign w_hist_n = {r_hist, x};
   assign w_mask   = len_mask(32'(r_len));
   assign w_diff   = MASK_W'(w_hist_n ^ r_pat);
   assign w_len_ok = (len != '0) && (len <= LEN_W'(MAX_LEN));
   assign w_sample = (r_state == ST_RUN) && en && !cfg_load;
   assign w_match  = w_sample && (w_fill_inc == r_len) && ((w_diff & w_mask) == '0);

   // Fill count after accepting one more bit, capped at the latched length.
   always_comb begin
      w_fill_inc = r_len;
      if (r_fill < r_len) begin
         w_fill_inc = r_fill + LEN_W'(1);
      end
   end

   // Control FSM, history shift register, fill counter and registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= ST_IDLE;
         r_hist    <= '0;
         r_fill    <= '0;
         r_pat     <= '0;
         r_len     <= '0;
         r_ovl     <= 1'b0;
         r_z       <= 1'b0;
         r_cfg_err <= 1'b0;
      end else if (cfg_load) begin
         // Reconfiguration from any state; the bit on this edge is dropped.
         r_pat     <= pattern;
         r_len     <= len;
         r_ovl     <= overlap;
         r_hist    <= '0;
         r_fill    <= '0;
         r_z       <= 1'b0;
         r_cfg_err <= !w_len_ok;
         r_state   <= w_len_ok ? ST_RUN : ST_ERR;
      end else begin
         r_z <= 1'b0;
         unique case (r_state)
            ST_RUN: begin
               if (en) begin
                  r_hist <= w_hist_n[MAX_LEN-2:0];
                  r_z    <= w_match;
                  // Non-overlapping: a match consumes all its bits.
                  r_fill <= (w_match && !r_ovl) ? '0 : w_fill_inc;
               end
            end
            ST_IDLE, ST_ERR: begin
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   seqdet_match_cnt #(
      .CNT_W (CNT_W)
   ) u_match_cnt (
      .clk   (clk),
      .rst   (rst),
      .i_clr (cfg_load),
      .i_inc (w_match),
      .o_cnt (match_cnt)
   );

   assign z       = r_z;
   assign cfg_err = r_cfg_err;
   assign state   = r_state;
   assign fill    = r_fill;

endmodule

// File: tb/tb_seq_detector_param.sv
// Self-checking bench for seq_detector_param: constant vector table,
// directed corner sequences and random traffic against a queue-based model.
module tb_seq_detector_param;

   localparam int unsigned MAX_LEN = 8;
   localparam int unsigned LEN_W   = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       cfg_load;
   logic [7:0] pattern;
   logic [3:0] len;
   logic       overlap;
   logic       en;
   logic       x;

   logic       z;
   logic [7:0] match_cnt;
   logic       cfg_err;
   logic [1:0] state;
   logic [3:0] fill;

   // Second instance with a 2-bit counter for the saturation corner.
   logic       z_s;
   logic [1:0] cnt_s;
   logic       err_s;
   logic [1:0] state_s;
   logic [3:0] fill_s;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   seq_detector_param #(.MAX_LEN(MAX_LEN), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .cfg_load(cfg_load), .pattern(pattern), .len(len),
      .overlap(overlap), .en(en), .x(x), .z(z), .match_cnt(match_cnt),
      .cfg_err(cfg_err), .state(state), .fill(fill)
   );

   seq_detector_param #(.MAX_LEN(MAX_LEN), .CNT_W(2)) dut_s (
      .clk(clk), .rst(rst), .cfg_load(cfg_load), .pattern(pattern), .len(len),
      .overlap(overlap), .en(en), .x(x), .z(z_s), .match_cnt(cnt_s),
      .cfg_err(err_s), .state(state_s), .fill(fill_s)
   );

   // ---------------- reference model ----------------
   // Received bits still eligible for a match are kept in a queue (oldest first).
   int         m_state;
   bit         m_q[$];
   logic [7:0] m_pat;
   int         m_len;
   bit         m_ovl;
   int         m_cnt;
   int         m_cnt_s;
   bit         m_z;
   bit         m_err;

   task automatic model_reset();
      m_state = 0; m_q.delete(); m_pat = '0; m_len = 0; m_ovl = 0;
      m_cnt = 0; m_cnt_s = 0; m_z = 0; m_err = 0;
   endtask

   task automatic model_step();
      bit hit;
      if (cfg_load) begin
         m_pat = pattern; m_len = int'(len); m_ovl = overlap;
         m_q.delete(); m_cnt = 0; m_cnt_s = 0; m_z = 0;
         m_err   = !(m_len >= 1 && m_len <= int'(MAX_LEN));
         m_state = m_err ? 2 : 1;
      end else if (m_state == 1 && en) begin
         m_q.push_back(x);
         if (m_q.size() > m_len) void'(m_q.pop_front());
         hit = (m_q.size() == m_len);
         for (int i = 0; i < m_len && hit; i++) begin
            if (m_q[i] != m_pat[m_len-1-i]) hit = 0;
         end
         m_z = hit;
         if (hit) begin
            if (m_cnt < 255) m_cnt++;
            if (m_cnt_s < 3) m_cnt_s++;
            if (!m_ovl) m_q.delete();
         end
      end else begin
         m_z = 0;
      end
   endtask

   // ---------------- checking helpers ----------------
   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic cmp_model(input string tag);
      chk({tag, " z"},       int'(z),         int'(m_z));
      chk({tag, " cnt"},     int'(match_cnt), m_cnt);
      chk({tag, " cfg_err"}, int'(cfg_err),   int'(m_err));
      chk({tag, " state"},   int'(state),     m_state);
      chk({tag, " fill"},    int'(fill),      m_q.size());
      chk({tag, " cnt_s"},   int'(cnt_s),     m_cnt_s);
      chk({tag, " z_s"},     int'(z_s),       int'(m_z));
   endtask

   task automatic apply(input logic c, input logic [7:0] p, input logic [3:0] l,
                        input logic o, input logic e, input logic b, input string tag);
      cfg_load = c; pattern = p; len = l; overlap = o; en = e; x = b;
      model_step();
      @(posedge clk);
      #1;
      cmp_model(tag);
   endtask

   // Configuration currently latched, reused by send().
   logic [7:0] c_pat;
   logic [3:0] c_len;
   logic       c_ovl;

   task automatic configure(input logic [7:0] p, input logic [3:0] l, input logic o,
                            input string tag);
      c_pat = p; c_len = l; c_ovl = o;
      apply(1'b1, p, l, o, 1'b0, 1'b0, tag);
   endtask

   // Sends n bits, first bit = bits[n-1]; zv[k] is z after the (k+1)th bit.
   task automatic send(input logic [15:0] bits, input int n, input string tag,
                       output logic [15:0] zv);
      zv = '0;
      for (int k = 0; k < n; k++) begin
         apply(1'b0, c_pat, c_len, c_ovl, 1'b1, bits[n-1-k], tag);
         zv[k] = z;
      end
   endtask

   // ---------------- constant vector table ----------------
   typedef struct {
      logic       c;
      logic [7:0] p;
      logic [3:0] l;
      logic       o;
      logic       e;
      logic       b;
      logic       z;
      int         cnt;
      int         st;
      int         fl;
   } vec_t;

   vec_t vt[8];

   logic [15:0] zv;

   initial begin
      // Five 1s, non-overlapping: match on bit 5 only, fill restarts.
      vt[0] = '{1'b1, 8'h1F, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1, 0};
      vt[1] = '{1'b0, 8'h1F, 4'd5, 1'b0, 1'b1, 1'b1, 1'b0, 0, 1, 1};
      vt[2] = '{1'b0, 8'h1F, 4'd5, 1'b0, 1'b1, 1'b1, 1'b0, 0, 1, 2};
      vt[3] = '{1'b0, 8'h1F, 4'd5, 1'b0, 1'b1, 1'b1, 1'b0, 0, 1, 3};
      vt[4] = '{1'b0, 8'h1F, 4'd5, 1'b0, 1'b1, 1'b1, 1'b0, 0, 1, 4};
      vt[5] = '{1'b0, 8'h1F, 4'd5, 1'b0, 1'b1, 1'b1, 1'b1, 1, 1, 0};
      vt[6] = '{1'b0, 8'h1F, 4'd5, 1'b0, 1'b1, 1'b1, 1'b0, 1, 1, 1};
      vt[7] = '{1'b0, 8'h1F, 4'd5, 1'b0, 1'b1, 1'b1, 1'b0, 1, 1, 2};

      rst = 1'b0; cfg_load = 0; pattern = '0; len = '0; overlap = 0; en = 0; x = 0;
      model_reset();
      #2;
      chk("reset z", int'(z), 0);
      chk("reset cnt", int'(match_cnt), 0);
      chk("reset cfg_err", int'(cfg_err), 0);
      chk("reset state", int'(state), 0);
      chk("reset fill", int'(fill), 0);
      @(negedge clk);
      rst = 1'b1;

      // IDLE ignores samples before any cfg_load.
      for (int k = 0; k < 3; k++) apply(1'b0, 8'h01, 4'd1, 1'b0, 1'b1, 1'b1, "idle");
      chk("idle state", int'(state), 0);

      for (int i = 0; i < 8; i++) begin
         apply(vt[i].c, vt[i].p, vt[i].l, vt[i].o, vt[i].e, vt[i].b, "vec");
         chk($sformatf("vec%0d z", i),     int'(z),         int'(vt[i].z));
         chk($sformatf("vec%0d cnt", i),   int'(match_cnt), vt[i].cnt);
         chk($sformatf("vec%0d state", i), int'(state),     vt[i].st);
         chk($sformatf("vec%0d fill", i),  int'(fill),      vt[i].fl);
      end

      // Five 1s overlapping: matches after bits 5, 6, 7.
      configure(8'h1F, 4'd5, 1'b1, "ovl5 cfg");
      send(16'h7F, 7, "ovl5", zv);
      chk("ovl5 zv", int'(zv), 'h70);
      chk("ovl5 cnt", int'(match_cnt), 3);

      // 1011 with overlap: after bits 4 and 7; without: bit 4 only.
      configure(8'h0B, 4'd4, 1'b1, "p1011o cfg");
      send(16'h5B, 7, "p1011o", zv);
      chk("p1011 ovl zv", int'(zv), 'h48);
      configure(8'h0B, 4'd4, 1'b0, "p1011n cfg");
      send(16'h5B, 7, "p1011n", zv);
      chk("p1011 novl zv", int'(zv), 'h08);

      // Enable gating: 1,0,1 then en=0 with toggling x, then final 1.
      configure(8'h0B, 4'd4, 1'b0, "gate cfg");
      send(16'h5, 3, "gate pre", zv);
      for (int k = 0; k < 4; k++) begin
         apply(1'b0, c_pat, c_len, c_ovl, 1'b0, k[0], "gate idle");
         chk("gate idle z", int'(z), 0);
      end
      chk("gate fill held", int'(fill), 3);
      send(16'h1, 1, "gate last", zv);
      chk("gate match z", int'(zv[0]), 1);
      chk("gate cnt", int'(match_cnt), 1);

      // Config errors: len=0 and len>MAX_LEN go to ERR and suppress z.
      configure(8'h01, 4'd0, 1'b0, "err0 cfg");
      chk("err0 state", int'(state), 2);
      chk("err0 flag", int'(cfg_err), 1);
      send(16'hFF, 8, "err0 bits", zv);
      chk("err0 zv", int'(zv), 0);
      configure(8'hFF, 4'd9, 1'b1, "err9 cfg");
      chk("err9 state", int'(state), 2);
      send(16'hFF, 8, "err9 bits", zv);
      chk("err9 zv", int'(zv), 0);
      configure(8'h01, 4'd1, 1'b0, "recover cfg");
      chk("recover state", int'(state), 1);
      chk("recover flag", int'(cfg_err), 0);

      // len=1 saturation: 2-bit counter stops at 3, 8-bit at 255.
      configure(8'h01, 4'd1, 1'b0, "sat cfg");
      send(16'h3F, 6, "sat6", zv);
      chk("sat6 zv", int'(zv), 'h3F);
      chk("sat cnt_s", int'(cnt_s), 3);
      for (int k = 0; k < 260; k++) apply(1'b0, c_pat, c_len, c_ovl, 1'b1, 1'b1, "sat");
      chk("sat cnt 255", int'(match_cnt), 255);

      // Async reset between edges mid-stream.
      configure(8'h1F, 4'd5, 1'b1, "rst cfg");
      send(16'h1F, 5, "rst pre", zv);
      chk("rst pre z", int'(z), 1);
      @(negedge clk);
      rst = 1'b0;
      #1;
      model_reset();
      chk("arst z", int'(z), 0);
      chk("arst cnt", int'(match_cnt), 0);
      chk("arst state", int'(state), 0);
      chk("arst fill", int'(fill), 0);
      chk("arst cfg_err", int'(cfg_err), 0);
      @(negedge clk);
      rst = 1'b1;
      for (int k = 0; k < 6; k++) apply(1'b0, 8'h1F, 4'd5, 1'b1, 1'b1, 1'b1, "post rst");
      chk("post rst state", int'(state), 0);

      // Random traffic; pattern/len/overlap wiggle freely between cfg_loads.
      configure(8'h05, 4'd3, 1'b1, "rnd cfg");
      for (int k = 0; k < 800; k++) begin
         logic       rc;
         logic [3:0] rl;
         rc = ($urandom_range(0, 24) == 0);
         rl = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15))
                                          : 4'($urandom_range(1, 4));
         apply(rc, 8'($urandom), rl, 1'($urandom), ($urandom_range(0, 3) != 0),
               1'($urandom), "rnd");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
